intr_ctrl: RTL and testbench

- Machine-mode interrupt controller for the 3-stage pipelined RISC-V core.
- Synchronises the timer (t_intr) and external (e_intr) interrupt lines and arbitrates them against the CSR enables.
- Picks the commit point in the M/W stage and sequences trap entry: flush, redirect to mtvec, mepc/mcause write. It also sequences the mret return.
- Sits between the core top, the CSR register file and the PC/flush logic.

---
 rtl/intr_pkg.sv | 29 ++
 rtl/sync_ff.sv | 29 ++
 rtl/intr_ctrl.sv | 139 +++++++++++++
 tb/tb_intr_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared types, constants and trap-vector helper for the machine-mode interrupt controller.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HANDLER
  } state_e;

  localparam int unsigned XLEN = 32;

  localparam int unsigned CAUSE_MTI_CODE = 7;
  localparam int unsigned CAUSE_MEI_CODE = 11;

  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_VECTORED = 2'd1;

  // Reserved modes 2 and 3 fall back to direct.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input int unsigned     code);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == MODE_VECTORED) begin
      return base + (XLEN'(code) << 2);
    end
    return base;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous level inputs; output lags input by SYNC_STAGES cycles.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: synchronises the interrupt lines, arbitrates them against
// the CSR enables and sequences trap entry at an M/W commit point and the mret return.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CAUSE_MTI   = intr_pkg::CAUSE_MTI_CODE,
  parameter int unsigned CAUSE_MEI   = intr_pkg::CAUSE_MEI_CODE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          t_intr_i,
  input  logic          e_intr_i,
  input  logic          mstatus_mie_i,
  input  logic          mie_mtie_i,
  input  logic          mie_meie_i,
  input  logic [DW-1:0] mtvec_i,
  input  logic [DW-1:0] mepc_i,
  input  logic [DW-1:0] pc_m_i,
  input  logic          valid_m_i,
  input  logic          stall_mw_i,
  input  logic          mret_m_i,
  output logic          mip_mtip_o,
  output logic          mip_meip_o,
  output logic          trap_o,
  output logic [DW-1:0] redirect_pc_o,
  output logic          mret_o,
  output logic          epc_we_o,
  output logic [DW-1:0] epc_o,
  output logic          cause_we_o,
  output logic [DW-1:0] cause_o,
  output logic          mie_clr_o
);

  state_e      r_state;
  state_e      w_stateNext;
  logic        r_mei;
  logic        w_meiNext;
  logic        r_mtip;
  logic        w_meip;
  logic        w_meiReq;
  logic        w_mtiReq;
  logic        w_take;
  logic        w_commit;
  logic        w_mretFire;
  int unsigned w_code;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (1)
  ) u_eSync (
    .i_clk(clk_i),
    .i_rst(rst_i),
    .i_d  (e_intr_i),
    .o_q  (w_meip)
  );

  assign mip_meip_o = w_meip;
  assign mip_mtip_o = r_mtip;

  assign w_meiReq   = w_meip & mie_meie_i;
  assign w_mtiReq   = r_mtip & mie_mtie_i;
  assign w_take     = mstatus_mie_i & (w_meiReq | w_mtiReq);
  assign w_commit   = valid_m_i & ~stall_mw_i & ~mret_m_i;
  assign w_mretFire = valid_m_i & ~stall_mw_i & mret_m_i;

  // A just-arrived MEI still wins over a latched MTI in the commit cycle itself.
  assign w_code = (r_mei | w_meiReq) ? CAUSE_MEI : CAUSE_MTI;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_mei   <= 1'b0;
      r_mtip  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_mei   <= w_meiNext;
      r_mtip  <= t_intr_i;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_meiNext     = r_mei;
    trap_o        = 1'b0;
    mret_o        = 1'b0;
    redirect_pc_o = '0;
    epc_we_o      = 1'b0;
    epc_o         = '0;
    cause_we_o    = 1'b0;
    cause_o       = '0;
    mie_clr_o     = 1'b0;
    if (!rst_i) begin
      case (r_state)
        IDLE: begin
          if (w_mretFire) begin
            mret_o        = 1'b1;
            redirect_pc_o = mepc_i;
          end
          if (w_take) begin
            w_stateNext = ARM;
            w_meiNext   = w_meiReq;
          end
        end
        ARM: begin
          if (w_mretFire) begin
            mret_o        = 1'b1;
            redirect_pc_o = mepc_i;
            w_stateNext   = IDLE;
          end else if (!w_take) begin
            w_stateNext = IDLE;
          end else if (w_commit) begin
            // The committing instruction is squashed and re-executes after the handler.
            trap_o        = 1'b1;
            mie_clr_o     = 1'b1;
            epc_we_o      = 1'b1;
            epc_o         = pc_m_i;
            cause_we_o    = 1'b1;
            cause_o       = {1'b1, (DW-1)'(w_code)};
            redirect_pc_o = DW'(trap_target(XLEN'(mtvec_i), w_code));
            w_stateNext   = HANDLER;
          end else begin
            w_meiNext = r_mei | w_meiReq;
          end
        end
        HANDLER: begin
          if (w_mretFire) begin
            mret_o        = 1'b1;
            redirect_pc_o = mepc_i;
            w_stateNext   = IDLE;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl with hand-computed expected values.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tIntr;
  logic        eIntr;
  logic        mstatusMie;
  logic        mieMtie;
  logic        mieMeie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] pcM;
  logic        validM;
  logic        stallMw;
  logic        mretM;
  logic        mipMtip;
  logic        mipMeip;
  logic        trap;
  logic [31:0] redirectPc;
  logic        mretPulse;
  logic        epcWe;
  logic [31:0] epc;
  logic        causeWe;
  logic [31:0] cause;
  logic        mieClr;

  int checks   = 0;
  int errors   = 0;
  int trapSeen = 0;
  int trapBase;

  always #5 clk = ~clk;

  intr_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .t_intr_i     (tIntr),
    .e_intr_i     (eIntr),
    .mstatus_mie_i(mstatusMie),
    .mie_mtie_i   (mieMtie),
    .mie_meie_i   (mieMeie),
    .mtvec_i      (mtvec),
    .mepc_i       (mepc),
    .pc_m_i       (pcM),
    .valid_m_i    (validM),
    .stall_mw_i   (stallMw),
    .mret_m_i     (mretM),
    .mip_mtip_o   (mipMtip),
    .mip_meip_o   (mipMeip),
    .trap_o       (trap),
    .redirect_pc_o(redirectPc),
    .mret_o       (mretPulse),
    .epc_we_o     (epcWe),
    .epc_o        (epc),
    .cause_we_o   (causeWe),
    .cause_o      (cause),
    .mie_clr_o    (mieClr)
  );

  // Counts trap pulses mid-cycle so that duplicate traps are caught.
  always @(negedge clk) begin
    if (trap === 1'b1) trapSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic t, input logic e, input logic valid,
                               input logic stall, input logic mretIn, input logic [31:0] pc);
    tIntr   = t;
    eIntr   = e;
    validM  = valid;
    stallMw = stall;
    mretM   = mretIn;
    pcM     = pc;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tIntr = 1'b0; eIntr = 1'b0;
    mstatusMie = 1'b0; mieMtie = 1'b0; mieMeie = 1'b0;
    mtvec = '0; mepc = '0; pcM = '0; validM = 1'b0; stallMw = 1'b0; mretM = 1'b0;
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset trap", 32'(trap), 32'h0);
    checkOutput("reset mret", 32'(mretPulse), 32'h0);
    checkOutput("reset epcWe", 32'(epcWe), 32'h0);
    checkOutput("reset causeWe", 32'(causeWe), 32'h0);
    checkOutput("reset mieClr", 32'(mieClr), 32'h0);
    checkOutput("reset mtip", 32'(mipMtip), 32'h0);
    checkOutput("reset meip", 32'(mipMeip), 32'h0);
    checkOutput("reset redirect", redirectPc, 32'h0);
    checkOutput("reset epc", epc, 32'h0);
    checkOutput("reset cause", cause, 32'h0);

    // Direct-mode timer trap
    rst = 1'b0; mstatusMie = 1'b1; mieMtie = 1'b1; mtvec = 32'h100;
    applyStimulus(1, 0, 1, 0, 0, 32'h40);
    checkOutput("t1 no trap before mtip", 32'(trap), 32'h0);
    nextCycle();
    checkOutput("t1 mtip one cycle", 32'(mipMtip), 32'h1);
    checkOutput("t1 idle no trap", 32'(trap), 32'h0);
    nextCycle();
    checkOutput("t1 trap", 32'(trap), 32'h1);
    checkOutput("t1 redirect", redirectPc, 32'h100);
    checkOutput("t1 epc", epc, 32'h40);
    checkOutput("t1 cause", cause, 32'h80000007);
    checkOutput("t1 mieClr", 32'(mieClr), 32'h1);
    checkOutput("t1 epcWe", 32'(epcWe), 32'h1);
    checkOutput("t1 causeWe", 32'(causeWe), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    nextCycle();
    mepc = 32'h40;
    applyStimulus(0, 0, 1, 0, 1, 32'h44);
    checkOutput("t1 mret pulse", 32'(mretPulse), 32'h1);
    checkOutput("t1 mret redirect", redirectPc, 32'h40);
    checkOutput("t1 mret no trap", 32'(trap), 32'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1 quiet mret", 32'(mretPulse), 32'h0);
    checkOutput("t1 quiet redirect", redirectPc, 32'h0);

    // Vectored external trap through the synchroniser
    mtvec = 32'h101; mieMeie = 1'b1;
    applyStimulus(0, 1, 1, 0, 0, 32'h80);
    nextCycle();
    checkOutput("t2 meip after 1", 32'(mipMeip), 32'h0);
    nextCycle();
    checkOutput("t2 meip after 2", 32'(mipMeip), 32'h1);
    checkOutput("t2 idle no trap", 32'(trap), 32'h0);
    nextCycle();
    checkOutput("t2 trap", 32'(trap), 32'h1);
    checkOutput("t2 redirect vectored", redirectPc, 32'h12C);
    checkOutput("t2 cause", cause, 32'h8000000B);
    checkOutput("t2 epc", epc, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    nextCycle();
    mepc = 32'h80;
    applyStimulus(0, 0, 1, 0, 1, 32'h84);
    checkOutput("t2 mret pulse", 32'(mretPulse), 32'h1);
    checkOutput("t2 mret redirect", redirectPc, 32'h80);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    nextCycle();

    // Simultaneous lines: one MEI trap, nothing more until mret
    mtvec = 32'h100;
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    nextCycle();
    nextCycle();
    nextCycle();
    trapBase = trapSeen;
    applyStimulus(1, 1, 1, 0, 0, 32'h90);
    checkOutput("t3 trap", 32'(trap), 32'h1);
    checkOutput("t3 cause MEI wins", cause, 32'h8000000B);
    checkOutput("t3 redirect", redirectPc, 32'h100);
    checkOutput("t3 epc", epc, 32'h90);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1, 0, 1, 0, 0, 32'h94);
      checkOutput("t3 blocked in handler", 32'(trap), 32'h0);
    end
    checkOutput("t3 single trap", 32'(trapSeen - trapBase), 32'h1);
    mepc = 32'h90;
    applyStimulus(1, 0, 1, 0, 1, 32'h98);
    checkOutput("t3 mret pulse", 32'(mretPulse), 32'h1);
    checkOutput("t3 mret redirect", redirectPc, 32'h90);
    checkOutput("t3 mret no trap", 32'(trap), 32'h0);

    // Stalls and a bubble hold the trap off until pc 0x58 commits
    nextCycle();
    applyStimulus(1, 0, 1, 1, 0, 32'h50);
    checkOutput("t4 idle after mret", 32'(trap), 32'h0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 32'h50);
      checkOutput("t4 stalled", 32'(trap), 32'h0);
      nextCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h54);
    checkOutput("t4 bubble", 32'(trap), 32'h0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 32'h58);
    checkOutput("t4 trap", 32'(trap), 32'h1);
    checkOutput("t4 epc", epc, 32'h58);
    checkOutput("t4 cause", cause, 32'h80000007);

    // Handler ignores pending MTI; mret returns and the controller re-arms
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 32'h5C);
    checkOutput("t5 handler no trap", 32'(trap), 32'h0);
    nextCycle();
    mepc = 32'h58;
    applyStimulus(1, 0, 1, 0, 1, 32'h60);
    checkOutput("t5 mret pulse", 32'(mretPulse), 32'h1);
    checkOutput("t5 mret redirect", redirectPc, 32'h58);
    checkOutput("t5 mret no trap", 32'(trap), 32'h0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 32'h58);
    checkOutput("t5 idle cycle", 32'(trap), 32'h0);
    checkOutput("t5 mret cleared", 32'(mretPulse), 32'h0);
    nextCycle();
    checkOutput("t5 rearm trap", 32'(trap), 32'h1);
    checkOutput("t5 rearm epc", epc, 32'h58);
    nextCycle();
    applyStimulus(0, 0, 1, 0, 1, 32'h58);
    checkOutput("t5 second mret", 32'(mretPulse), 32'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // Global enable off: lines visible in mip, no trap
    mstatusMie = 1'b0;
    trapBase = trapSeen;
    applyStimulus(1, 1, 1, 0, 0, 32'h70);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("t6 mtip visible", 32'(mipMtip), 32'h1);
    checkOutput("t6 meip visible", 32'(mipMeip), 32'h1);
    checkOutput("t6 no trap", 32'(trap), 32'h0);
    checkOutput("t6 no trap count", 32'(trapSeen - trapBase), 32'h0);

    // Reset while armed
    mstatusMie = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 32'h74);
    checkOutput("t7 rst suppresses trap", 32'(trap), 32'h0);
    checkOutput("t7 rst suppresses epcWe", 32'(epcWe), 32'h0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("t7 mtip cleared", 32'(mipMtip), 32'h0);
    checkOutput("t7 meip cleared", 32'(mipMeip), 32'h0);
    checkOutput("t7 idle no trap", 32'(trap), 32'h0);
    checkOutput("t7 cause cleared", cause, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
